operand_fetch: RTL and testbench

OPERAND_FETCH -- requirements
Module: operand_fetch

---
 rtl/regfile_pkg.sv | 8 +
 rtl/reg_scoreboard.sv | 47 ++++
 rtl/operand_fetch.sv | 148 ++++++++++++++
 tb/tb_operand_fetch.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared widths and the operand-fetch state encoding for the register-file front end.
package regfile_pkg;
  localparam int unsigned XLEN          = 32;
  localparam int unsigned ADDR_SIZE     = 6;
  localparam int unsigned NUM_REGISTERS = 32;

  typedef enum logic [1:0] {IDLE, RD_WAIT, OUT_VALID} fetch_state_t;
endpackage

// File: rtl/reg_scoreboard.sv
// One pending bit per architectural register; set beats clear, x0 and unimplemented slots
// are hard-wired to 0.
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_SIZE     = regfile_pkg::ADDR_SIZE,
  parameter int unsigned NUM_REGISTERS = regfile_pkg::NUM_REGISTERS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 set_en,
  input  logic [ADDR_SIZE-1:0] set_addr,
  input  logic                 clr_en,
  input  logic [ADDR_SIZE-1:0] clr_addr,
  input  logic [ADDR_SIZE-1:0] rs1_addr,
  input  logic [ADDR_SIZE-1:0] rs2_addr,
  input  logic [ADDR_SIZE-1:0] rd_addr,
  output logic                 rs1_pending,
  output logic                 rs2_pending,
  output logic                 rd_pending
);
  localparam int unsigned Depth = 1 << ADDR_SIZE;

  logic [Depth-1:0] w_pending;

  for (genvar i = 0; i < Depth; i++) begin : g_bit
    if (i == 0 || i >= NUM_REGISTERS) begin : g_tie
      assign w_pending[i] = 1'b0;
    end else begin : g_flop
      logic r_bit;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_bit <= 1'b0;
        end else if (set_en && (set_addr == ADDR_SIZE'(i))) begin
          r_bit <= 1'b1;
        end else if (clr_en && (clr_addr == ADDR_SIZE'(i))) begin
          r_bit <= 1'b0;
        end
      end
      assign w_pending[i] = r_bit;
    end
  end

  assign rs1_pending = w_pending[rs1_addr];
  assign rs2_pending = w_pending[rs2_addr];
  assign rd_pending  = w_pending[rd_addr];
endmodule

// File: rtl/operand_fetch.sv
// Hazard-checked operand fetch: reads the register file, forwards a same-cycle writeback,
// and presents operands to execute under a valid/ready handshake.
module operand_fetch #(
  parameter int unsigned XLEN          = regfile_pkg::XLEN,
  parameter int unsigned ADDR_SIZE     = regfile_pkg::ADDR_SIZE,
  parameter int unsigned NUM_REGISTERS = regfile_pkg::NUM_REGISTERS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dec_valid,
  output logic                 dec_ready,
  input  logic [ADDR_SIZE-1:0] dec_rs1,
  input  logic [ADDR_SIZE-1:0] dec_rs2,
  input  logic                 dec_uses_rs1,
  input  logic                 dec_uses_rs2,
  input  logic [ADDR_SIZE-1:0] dec_rd,
  input  logic                 dec_rd_we,
  output logic                 rf_read_enable1,
  output logic                 rf_read_enable2,
  output logic [ADDR_SIZE-1:0] rf_read_addr1,
  output logic [ADDR_SIZE-1:0] rf_read_addr2,
  input  logic [XLEN-1:0]      rf_read_data1,
  input  logic [XLEN-1:0]      rf_read_data2,
  output logic                 rf_write_enable,
  output logic [ADDR_SIZE-1:0] rf_write_addr,
  output logic [XLEN-1:0]      rf_write_data,
  input  logic                 wb_valid,
  input  logic [ADDR_SIZE-1:0] wb_addr,
  input  logic [XLEN-1:0]      wb_data,
  output logic                 ex_valid,
  input  logic                 ex_ready,
  output logic [XLEN-1:0]      ex_op1,
  output logic [XLEN-1:0]      ex_op2,
  output logic [ADDR_SIZE-1:0] ex_rd,
  output logic                 ex_rd_we
);
  import regfile_pkg::*;

  fetch_state_t          r_state;
  logic [ADDR_SIZE-1:0]  r_rs1, r_rs2;
  logic                  r_uses1, r_uses2;
  logic                  r_fwd1, r_fwd2;
  logic [XLEN-1:0]       r_fwd_data1, r_fwd_data2;
  logic                  r_ex_valid, r_ex_rd_we;
  logic [XLEN-1:0]       r_ex_op1, r_ex_op2;
  logic [ADDR_SIZE-1:0]  r_ex_rd;

  logic w_pend1, w_pend2, w_pend_rd;
  logic w_hit1, w_hit2, w_raw1, w_raw2, w_waw, w_accept, w_set_en;

  reg_scoreboard #(
    .ADDR_SIZE     (ADDR_SIZE),
    .NUM_REGISTERS (NUM_REGISTERS)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .set_en      (w_set_en),
    .set_addr    (dec_rd),
    .clr_en      (wb_valid),
    .clr_addr    (wb_addr),
    .rs1_addr    (dec_rs1),
    .rs2_addr    (dec_rs2),
    .rd_addr     (dec_rd),
    .rs1_pending (w_pend1),
    .rs2_pending (w_pend2),
    .rd_pending  (w_pend_rd)
  );

  // A writeback landing this cycle resolves a RAW hazard; it is forwarded below.
  assign w_hit1   = wb_valid && (wb_addr == dec_rs1) && (dec_rs1 != '0);
  assign w_hit2   = wb_valid && (wb_addr == dec_rs2) && (dec_rs2 != '0);
  assign w_raw1   = dec_uses_rs1 && (dec_rs1 != '0) && w_pend1 && !w_hit1;
  assign w_raw2   = dec_uses_rs2 && (dec_rs2 != '0) && w_pend2 && !w_hit2;
  assign w_waw    = dec_rd_we && (dec_rd != '0) && w_pend_rd;
  assign dec_ready = !rst && (r_state == IDLE) && !w_raw1 && !w_raw2 && !w_waw;
  assign w_accept = dec_valid && dec_ready;
  assign w_set_en = w_accept && dec_rd_we && (dec_rd != '0);

  // Read strobes fire in the accept cycle so registered data arrives during RD_WAIT.
  assign rf_read_enable1 = w_accept;
  assign rf_read_enable2 = w_accept;
  assign rf_read_addr1   = w_accept ? dec_rs1 : '0;
  assign rf_read_addr2   = w_accept ? dec_rs2 : '0;

  assign rf_write_enable = wb_valid && (wb_addr != '0);
  assign rf_write_addr   = wb_addr;
  assign rf_write_data   = wb_data;

  assign ex_valid = r_ex_valid;
  assign ex_op1   = r_ex_op1;
  assign ex_op2   = r_ex_op2;
  assign ex_rd    = r_ex_rd;
  assign ex_rd_we = r_ex_rd_we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_uses1     <= 1'b0;
      r_uses2     <= 1'b0;
      r_fwd1      <= 1'b0;
      r_fwd2      <= 1'b0;
      r_fwd_data1 <= '0;
      r_fwd_data2 <= '0;
      r_ex_valid  <= 1'b0;
      r_ex_op1    <= '0;
      r_ex_op2    <= '0;
      r_ex_rd     <= '0;
      r_ex_rd_we  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_rs1       <= dec_rs1;
            r_rs2       <= dec_rs2;
            r_uses1     <= dec_uses_rs1;
            r_uses2     <= dec_uses_rs2;
            r_fwd1      <= w_hit1;
            r_fwd2      <= w_hit2;
            r_fwd_data1 <= wb_data;
            r_fwd_data2 <= wb_data;
            r_ex_rd     <= dec_rd;
            r_ex_rd_we  <= dec_rd_we;
            r_state     <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (!r_uses1 || (r_rs1 == '0)) r_ex_op1 <= '0;
          else if (r_fwd1)               r_ex_op1 <= r_fwd_data1;
          else                           r_ex_op1 <= rf_read_data1;
          if (!r_uses2 || (r_rs2 == '0)) r_ex_op2 <= '0;
          else if (r_fwd2)               r_ex_op2 <= r_fwd_data2;
          else                           r_ex_op2 <= rf_read_data2;
          r_ex_valid <= 1'b1;
          r_state    <= OUT_VALID;
        end
        OUT_VALID: begin
          if (ex_ready) begin
            r_ex_valid <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a register-file model and an expected-operand queue.
module tb_operand_fetch;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dec_valid = 1'b0, dec_ready;
  logic [5:0]  dec_rs1 = '0, dec_rs2 = '0, dec_rd = '0;
  logic        dec_uses_rs1 = 1'b0, dec_uses_rs2 = 1'b0, dec_rd_we = 1'b0;
  logic        rf_read_enable1, rf_read_enable2;
  logic [5:0]  rf_read_addr1, rf_read_addr2;
  logic [31:0] rf_read_data1 = '0, rf_read_data2 = '0;
  logic        rf_write_enable;
  logic [5:0]  rf_write_addr;
  logic [31:0] rf_write_data;
  logic        wb_valid = 1'b0;
  logic [5:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        ex_valid, ex_ready = 1'b1;
  logic [31:0] ex_op1, ex_op2;
  logic [5:0]  ex_rd;
  logic        ex_rd_we;

  typedef struct packed {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [5:0]  rd;
    logic        we;
  } exp_t;

  exp_t        q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] rf_mem [64];
  logic        force_ff = 1'b0;

  operand_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .dec_valid       (dec_valid),
    .dec_ready       (dec_ready),
    .dec_rs1         (dec_rs1),
    .dec_rs2         (dec_rs2),
    .dec_uses_rs1    (dec_uses_rs1),
    .dec_uses_rs2    (dec_uses_rs2),
    .dec_rd          (dec_rd),
    .dec_rd_we       (dec_rd_we),
    .rf_read_enable1 (rf_read_enable1),
    .rf_read_enable2 (rf_read_enable2),
    .rf_read_addr1   (rf_read_addr1),
    .rf_read_addr2   (rf_read_addr2),
    .rf_read_data1   (rf_read_data1),
    .rf_read_data2   (rf_read_data2),
    .rf_write_enable (rf_write_enable),
    .rf_write_addr   (rf_write_addr),
    .rf_write_data   (rf_write_data),
    .wb_valid        (wb_valid),
    .wb_addr         (wb_addr),
    .wb_data         (wb_data),
    .ex_valid        (ex_valid),
    .ex_ready        (ex_ready),
    .ex_op1          (ex_op1),
    .ex_op2          (ex_op2),
    .ex_rd           (ex_rd),
    .ex_rd_we        (ex_rd_we)
  );

  always #5 clk = ~clk;

  // Register-file model: registered reads return the value held before a same-edge write.
  always @(posedge clk) begin
    if (rf_write_enable) rf_mem[rf_write_addr] <= rf_write_data;
    if (rf_read_enable1) rf_read_data1 <= force_ff ? 32'hFFFF_FFFF : rf_mem[rf_read_addr1];
    if (rf_read_enable2) rf_read_data2 <= force_ff ? 32'hFFFF_FFFF : rf_mem[rf_read_addr2];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [5:0] rs1, input logic u1, input logic [5:0] rs2,
                       input logic u2, input logic [5:0] rd, input logic we);
    dec_valid = 1'b1;
    dec_rs1 = rs1; dec_uses_rs1 = u1;
    dec_rs2 = rs2; dec_uses_rs2 = u2;
    dec_rd  = rd;  dec_rd_we    = we;
  endtask

  task automatic push(input logic [31:0] op1, input logic [31:0] op2, input logic [5:0] rd,
                      input logic we);
    exp_t e;
    e.op1 = op1; e.op2 = op2; e.rd = rd; e.we = we;
    q.push_back(e);
  endtask

  // Every execute handshake must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && ex_valid && ex_ready) begin
      n_tests++;
      assert (q.size() != 0) else begin
        n_fail++;
        $error("FAIL ex_unexpected: observed op1 %h rd %0d expected no output", ex_op1, ex_rd);
      end
      if (q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        check("ex_op1", ex_op1, e.op1);
        check("ex_op2", ex_op2, e.op2);
        check("ex_rd", 32'(ex_rd), 32'(e.rd));
        check("ex_rd_we", 32'(ex_rd_we), 32'(e.we));
      end
    end
  end

  initial begin
    for (int i = 0; i < 64; i++) rf_mem[i] = '0;
    #2;
    check("rst_dec_ready", 32'(dec_ready), 0);
    check("rst_ex_valid", 32'(ex_valid), 0);
    check("rst_ex_op1", ex_op1, 0);
    check("rst_rd_en1", 32'(rf_read_enable1), 0);
    check("rst_rd_addr1", 32'(rf_read_addr1), 0);
    step();
    step();
    rst = 1'b0;

    // Preload x5 and x6 through writeback pass-through.
    wb_valid = 1'b1; wb_addr = 6'd5; wb_data = 32'h11;
    #1 check("wb_we_x5", 32'(rf_write_enable), 1);
    step();
    wb_addr = 6'd6; wb_data = 32'h22;
    step();
    wb_valid = 1'b0;

    // No hazard.
    issue(6'd5, 1'b1, 6'd6, 1'b1, 6'd10, 1'b0);
    #1;
    check("nh_dec_ready", 32'(dec_ready), 1);
    check("nh_rd_en1", 32'(rf_read_enable1), 1);
    check("nh_rd_en2", 32'(rf_read_enable2), 1);
    check("nh_rd_addr1", 32'(rf_read_addr1), 5);
    check("nh_rd_addr2", 32'(rf_read_addr2), 6);
    push(32'h11, 32'h22, 6'd10, 1'b0);
    step();
    dec_valid = 1'b0;
    #1;
    check("nh_rd_en1_pulse", 32'(rf_read_enable1), 0);
    check("nh_ex_valid_c1", 32'(ex_valid), 0);
    step();
    check("nh_ex_valid_c2", 32'(ex_valid), 1);
    step();
    check("nh_ex_valid_c3", 32'(ex_valid), 0);

    // RAW stall resolved by a same-cycle writeback.
    issue(6'd0, 1'b0, 6'd0, 1'b0, 6'd7, 1'b1);
    push(32'h0, 32'h0, 6'd7, 1'b1);
    step();
    dec_valid = 1'b0;
    step();
    step();
    issue(6'd7, 1'b1, 6'd0, 1'b0, 6'd11, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1 check("raw_stall", 32'(dec_ready), 0);
      check("raw_no_read", 32'(rf_read_enable1), 0);
      step();
    end
    wb_valid = 1'b1; wb_addr = 6'd7; wb_data = 32'hABCD;
    #1 check("raw_accept_on_wb", 32'(dec_ready), 1);
    push(32'hABCD, 32'h0, 6'd11, 1'b0);
    step();
    wb_valid = 1'b0; dec_valid = 1'b0;
    step();
    step();

    // x0 handling.
    force_ff = 1'b1;
    issue(6'd0, 1'b1, 6'd5, 1'b1, 6'd0, 1'b1);
    #1 check("x0_dec_ready", 32'(dec_ready), 1);
    push(32'h0, 32'hFFFF_FFFF, 6'd0, 1'b1);
    step();
    dec_valid = 1'b0;
    step();
    step();
    force_ff = 1'b0;
    wb_valid = 1'b1; wb_addr = 6'd0; wb_data = 32'h1234;
    #1 check("x0_wb_we", 32'(rf_write_enable), 0);
    step();
    wb_valid = 1'b0;

    // Backpressure.
    ex_ready = 1'b0;
    issue(6'd5, 1'b1, 6'd6, 1'b1, 6'd12, 1'b1);
    push(32'h11, 32'h22, 6'd12, 1'b1);
    step();
    dec_valid = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        wb_valid = 1'b1; wb_addr = 6'd20; wb_data = 32'h55;
        #1 check("bp_wb_we", 32'(rf_write_enable), 1);
        check("bp_wb_addr", 32'(rf_write_addr), 20);
      end
      check("bp_ex_valid", 32'(ex_valid), 1);
      check("bp_op1", ex_op1, 32'h11);
      check("bp_op2", ex_op2, 32'h22);
      check("bp_dec_ready", 32'(dec_ready), 0);
      step();
      wb_valid = 1'b0;
    end
    ex_ready = 1'b1;
    step();
    wb_valid = 1'b1; wb_addr = 6'd12; wb_data = 32'h77;
    step();
    wb_valid = 1'b0;

    // Set/clear race on x9, then a WAW stall.
    issue(6'd0, 1'b0, 6'd0, 1'b0, 6'd9, 1'b1);
    wb_valid = 1'b1; wb_addr = 6'd9; wb_data = 32'h33;
    #1 check("race_accept", 32'(dec_ready), 1);
    push(32'h0, 32'h0, 6'd9, 1'b1);
    step();
    dec_valid = 1'b0; wb_valid = 1'b0;
    step();
    step();
    issue(6'd0, 1'b0, 6'd0, 1'b0, 6'd9, 1'b1);
    #1 check("waw_stall", 32'(dec_ready), 0);
    step();
    check("waw_stall2", 32'(dec_ready), 0);
    wb_valid = 1'b1; wb_addr = 6'd9; wb_data = 32'h44;
    #1 check("waw_stall_wb", 32'(dec_ready), 0);
    step();
    wb_valid = 1'b0;
    #1 check("waw_release", 32'(dec_ready), 1);
    push(32'h0, 32'h0, 6'd9, 1'b1);
    step();
    dec_valid = 1'b0;
    step();
    step();

    // Reset during RD_WAIT.
    issue(6'd5, 1'b1, 6'd6, 1'b1, 6'd13, 1'b1);
    step();
    dec_valid = 1'b0;
    rst = 1'b1;
    #1 check("rstmid_ex_valid", 32'(ex_valid), 0);
    check("rstmid_dec_ready", 32'(dec_ready), 0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1 check("rstmid_no_valid", 32'(ex_valid), 0);
      step();
    end
    issue(6'd9, 1'b1, 6'd13, 1'b1, 6'd14, 1'b0);
    #1 check("rstmid_sb_empty", 32'(dec_ready), 1);
    push(32'h44, 32'h0, 6'd14, 1'b0);
    step();
    dec_valid = 1'b0;

    for (int i = 0; i < 20 && q.size() != 0; i++) step();
    step();
    check("queue_drained", 32'(q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
